// File: rtl/narc_regfile_p_if.sv
// Control/data bundle for narc_regfile_p: write port, capture controls, port B and VALID.
// The 3-state port A pad (ADDR) stays a plain module port so it resolves cleanly at the pin.
interface narc_regfile_p_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          WREN_N;
  logic [AW-1:0] WSEL;
  logic [1:0]    WOP;
  logic [DW-1:0] DATA;
  logic          RDEN;
  logic [AW:0]   RSELA;
  logic [AW:0]   RSELB;
  logic          OE_N;
  logic [DW-1:0] QB;
  logic          VALID;

  modport master (
    output WREN_N, WSEL, WOP, DATA, RDEN, RSELA, RSELB, OE_N,
    input  QB, VALID
  );

  modport slave (
    input  WREN_N, WSEL, WOP, DATA, RDEN, RSELA, RSELB, OE_N,
    output QB, VALID
  );
endinterface

// File: rtl/narc_regfile_p.sv
// Register file with hard-wired r0, increment/decrement write ops, two registered
// read ports with write-first bypass, constant selects and a 3-state port A.
module narc_regfile_p #(
  parameter  int DW   = 16,
  parameter  int NREG = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          RST,
  narc_regfile_p_if.slave bus,
  output wire  [DW-1:0] ADDR
);

  // Capture protocol: RDEN=1 at a rising edge loads both port registers;
  // VALID is RDEN delayed one cycle and marks the cycle the new data is visible.
  // There is no back-pressure: every capture is accepted.

  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;
  logic          valid;
  logic          wr_hit;
  logic [DW-1:0] cur;
  logic [DW-1:0] wval;
  logic [DW-1:0] nxt_a;
  logic [DW-1:0] nxt_b;

  function automatic logic [DW-1:0] const_val(input logic [1:0] code);
    case (code)
      2'b00:   return DW'(2);
      2'b01:   return DW'(1);
      2'b10:   return {DW{1'b1}} - DW'(1);
      default: return {DW{1'b1}};
    endcase
  endfunction

  always_comb begin
    wr_hit = !bus.WREN_N && (bus.WSEL != '0);
    cur    = regs[bus.WSEL];
    case (bus.WOP)
      2'b00:   wval = bus.DATA;
      2'b01:   wval = cur + DW'(1);
      2'b10:   wval = cur - DW'(1);
      default: wval = cur + DW'(2);
    endcase
  end

  // Write-first: a read of the register being written sees the post-op value.
  always_comb begin
    nxt_a = '0;
    if (bus.RSELA[AW])
      nxt_a = const_val(bus.RSELA[1:0]);
    else if (wr_hit && (bus.RSELA[AW-1:0] == bus.WSEL))
      nxt_a = wval;
    else
      nxt_a = regs[bus.RSELA[AW-1:0]];
  end

  always_comb begin
    nxt_b = '0;
    if (bus.RSELB[AW])
      nxt_b = const_val(bus.RSELB[1:0]);
    else if (wr_hit && (bus.RSELB[AW-1:0] == bus.WSEL))
      nxt_b = wval;
    else
      nxt_b = regs[bus.RSELB[AW-1:0]];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      qa    <= '0;
      qb    <= '0;
      valid <= 1'b0;
    end else begin
      if (wr_hit) regs[bus.WSEL] <= wval;
      if (bus.RDEN) begin
        qa <= nxt_a;
        qb <= nxt_b;
      end
      valid <= bus.RDEN;
    end
  end

  assign bus.QB    = qb;
  assign bus.VALID = valid;
  // Output enable gates only the pad, never the capture register.
  assign ADDR      = bus.OE_N ? {DW{1'bz}} : qa;

endmodule

// File: tb/tb_narc_regfile_p.sv
// Directed self-checking bench for narc_regfile_p at the default size and at DW=32, NREG=16.
module tb_narc_regfile_p;

  logic CLK;
  logic RST;

  narc_regfile_p_if #(.DW(16), .AW(3)) bus ();
  narc_regfile_p_if #(.DW(32), .AW(4)) bus2 ();
  // Pulled-up nets make a released (high-Z) port A read back as all ones.
  tri1 [15:0] addr;
  tri1 [31:0] addr2;

  narc_regfile_p #(.DW(16), .NREG(8)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .bus  (bus),
    .ADDR (addr)
  );

  narc_regfile_p #(.DW(32), .NREG(16)) dut2 (
    .CLK  (CLK),
    .RST  (RST),
    .bus  (bus2),
    .ADDR (addr2)
  );

  int checks = 0;
  int errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.WREN_N = 1'b1; bus.WSEL = '0; bus.WOP = 2'b00; bus.DATA = '0;
    bus.RDEN = 1'b0; bus.RSELA = '0; bus.RSELB = '0;
    bus2.WREN_N = 1'b1; bus2.WSEL = '0; bus2.WOP = 2'b00; bus2.DATA = '0;
    bus2.RDEN = 1'b0; bus2.RSELA = '0; bus2.RSELB = '0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [1:0] op, input logic [15:0] d);
    bus.WREN_N = 1'b0; bus.WSEL = sel; bus.WOP = op; bus.DATA = d;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b);
    bus.RDEN = 1'b1; bus.RSELA = a; bus.RSELB = b;
  endtask

  logic [15:0] const_exp [4];

  initial begin
    const_exp[0] = 16'h0002; const_exp[1] = 16'h0001;
    const_exp[2] = 16'hFFFE; const_exp[3] = 16'hFFFF;
    RST = 1'b1;
    bus.OE_N = 1'b0;
    bus2.OE_N = 1'b0;
    idle();
    tick(); tick();
    check("reset_addr", 32'(addr), 32'h0);
    check("reset_qb", 32'(bus.QB), 32'h0);
    check("reset_valid", 32'(bus.VALID), 32'h0);
    RST = 1'b0;

    // Load then read one cycle later
    wr(3'd1, 2'b00, 16'h1234); tick();
    idle(); rd(4'b0001, 4'b0000); tick();
    check("r1_load_addr", 32'(addr), 32'h1234);
    check("r1_load_valid", 32'(bus.VALID), 32'h1);
    idle(); tick();
    check("hold_addr", 32'(addr), 32'h1234);
    check("valid_drop", 32'(bus.VALID), 32'h0);

    // Bypass on B while A reads a different register (pre-cycle value)
    wr(3'd2, 2'b00, 16'hABCD); rd(4'b0001, 4'b0010); tick();
    check("bypass_qb", 32'(bus.QB), 32'hABCD);
    check("other_reg_addr", 32'(addr), 32'h1234);
    idle(); wr(3'd1, 2'b00, 16'h5A5A); rd(4'b0010, 4'b0001); tick();
    check("preval_addr_r2", 32'(addr), 32'hABCD);
    check("bypass_qb_r1", 32'(bus.QB), 32'h5A5A);

    // Wrap-around ops on r3, each observed through the bypass
    idle(); wr(3'd3, 2'b00, 16'hFFFF); tick();
    idle(); wr(3'd3, 2'b01, 16'h1111); rd(4'b0011, 4'b0000); tick();
    check("inc_wrap", 32'(addr), 32'h0000);
    idle(); wr(3'd3, 2'b10, 16'h2222); rd(4'b0011, 4'b0000); tick();
    check("dec_wrap", 32'(addr), 32'hFFFF);
    idle(); wr(3'd3, 2'b11, 16'h3333); rd(4'b0011, 4'b0000); tick();
    check("add2_wrap", 32'(addr), 32'h0001);
    idle(); rd(4'b0000, 4'b0011); tick();
    check("r3_stored", 32'(bus.QB), 32'h0001);

    // Constant selects, including ignored bit 2
    for (int i = 0; i < 4; i++) begin
      idle(); rd(4'b1000 | 4'(i), 4'b1100 | 4'(i)); tick();
      check($sformatf("const_a_%0d", i), 32'(addr), 32'(const_exp[i]));
      check($sformatf("const_b_hi_%0d", i), 32'(bus.QB), 32'(const_exp[i]));
    end

    // r0 ignores loads and ops
    idle(); wr(3'd0, 2'b00, 16'h5555); rd(4'b0000, 4'b0000); tick();
    check("r0_bypass", 32'(addr), 32'h0000);
    idle(); wr(3'd0, 2'b01, 16'h0); tick();
    idle(); rd(4'b0000, 4'b0000); tick();
    check("r0_read", 32'(addr), 32'h0000);
    check("r0_read_b", 32'(bus.QB), 32'h0000);

    // Same select on both ports
    idle(); rd(4'b0001, 4'b0001); tick();
    check("same_sel_a", 32'(addr), 32'h5A5A);
    check("same_sel_b", 32'(bus.QB), 32'h5A5A);

    // Output enable released: pad floats, captures continue
    bus.OE_N = 1'b1;
    idle(); rd(4'b0010, 4'b0011); tick();
    check("oe_hiz", 32'(addr), 32'hFFFF);
    check("oe_qb", 32'(bus.QB), 32'h0001);
    bus.OE_N = 1'b0;
    #1;
    check("oe_reappear", 32'(addr), 32'hABCD);
    idle(); bus.RSELA = 4'b0001; tick();
    check("rden0_hold", 32'(addr), 32'hABCD);

    // Reset overrides a write and a read in the same cycle
    wr(3'd1, 2'b00, 16'h7777); rd(4'b0001, 4'b0010);
    RST = 1'b1; tick();
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_qb", 32'(bus.QB), 32'h0);
    check("rst_valid", 32'(bus.VALID), 32'h0);
    RST = 1'b0;
    idle(); rd(4'b0001, 4'b0010); tick();
    check("post_rst_r1", 32'(addr), 32'h0);
    check("post_rst_r2", 32'(bus.QB), 32'h0);
    check("post_rst_valid", 32'(bus.VALID), 32'h1);
    idle(); rd(4'b0011, 4'b0011); tick();
    check("post_rst_r3", 32'(addr), 32'h0);

    // Wide instance: DW=32, NREG=16
    idle();
    bus2.WREN_N = 1'b0; bus2.WSEL = 4'd15; bus2.WOP = 2'b00; bus2.DATA = 32'hDEADBEEF; tick();
    bus2.WSEL = 4'd9; bus2.WOP = 2'b01; bus2.DATA = 32'h0;
    bus2.RDEN = 1'b1; bus2.RSELA = 5'b01111; bus2.RSELB = 5'b01001; tick();
    check("w_r15", addr2, 32'hDEADBEEF);
    check("w_r9_inc", bus2.QB, 32'h0000_0001);
    bus2.WREN_N = 1'b1; bus2.RSELA = 5'b10010; bus2.RSELB = 5'b11111; tick();
    check("w_const_m2", addr2, 32'hFFFF_FFFE);
    check("w_const_m1", bus2.QB, 32'hFFFF_FFFF);
    bus2.WREN_N = 1'b0; bus2.WSEL = 4'd15; bus2.WOP = 2'b00; bus2.DATA = 32'h1;
    bus2.RSELA = 5'b01111; bus2.RSELB = 5'b01001;
    RST = 1'b1; tick();
    check("w_rst_addr", addr2, 32'h0);
    check("w_rst_qb", bus2.QB, 32'h0);
    check("w_rst_valid", 32'(bus2.VALID), 32'h0);
    RST = 1'b0;
    bus2.WREN_N = 1'b1; tick();
    check("w_post_r15", addr2, 32'h0);
    check("w_post_r9", bus2.QB, 32'h0);
    check("w_post_valid", 32'(bus2.VALID), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
